// File: rtl/baby_nibble_alu_sequencer.sv
`timescale 1ns/1ps
// baby_nibble_alu_sequencer
// Nibble-serial controller that feeds one external asynchronous 4-bit full
// adder, LSB nibble first. Each nibble stays on the adder for SETTLE_CYCLES
// clocks, and the sum is then captured in a dedicated CAPTURE cycle. The
// carry is chained from one nibble to the next through a register.
//
// Handshake: start is looked at only in IDLE. busy rises on the accept edge
// and stays high until the final capture edge. At that edge busy falls and
// done rises for exactly one cycle, with result and flags valid. After DONE
// the block is back in IDLE and can take a new start on the next edge.
module baby_nibble_alu_sequencer #(
  parameter int WORD_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WORD_WIDTH-1:0] operand_a,
  input  logic [WORD_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  negative,
  output logic                  zero,
  output logic [3:0]            adder_a,
  output logic [3:0]            adder_b,
  output logic                  adder_c0,
  input  logic [3:0]            adder_s,
  input  logic                  adder_c4
);

  localparam int NIBBLES = WORD_WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CW      = $clog2(SETTLE_CYCLES + 1);

  localparam logic [IW-1:0] LAST_IDX    = IW'(NIBBLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [1:0]    OP_LOAD     = 2'b11;

  if ((WORD_WIDTH % 4) != 0 || WORD_WIDTH < 4) begin : g_bad_width
    $error("WORD_WIDTH must be a positive multiple of 4");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] a_word;     // conditioned first operand a'
  logic [WORD_WIDTH-1:0] b_word;     // conditioned second operand b'
  logic                  is_load;
  logic [IW-1:0]         nib_idx;
  logic [IW-1:0]         nib_next;
  logic [CW-1:0]         settle_cnt;

  logic [WORD_WIDTH-1:0] a_sel;
  logic [WORD_WIDTH-1:0] b_sel;
  logic                  cin_sel;
  logic [WORD_WIDTH-1:0] merged;

  assign nib_next = nib_idx + IW'(1);

  // Operand conditioning. SUB and NEG invert b and inject a carry of 1.
  // NEG and LOAD replace a with zero.
  always_comb begin
    a_sel   = op[1] ? '0 : operand_a;
    b_sel   = (op[0] ^ op[1]) ? ~operand_b : operand_b;
    cin_sel = op[0] ^ op[1];
  end

  // Result word as it will look after the current nibble is captured.
  always_comb begin
    merged = result;
    merged[{nib_idx, 2'b00} +: 4] = adder_s;
  end

  // Sequencer FSM. Every output is registered, so the adder drives change
  // only on clock edges and stay stable for the whole settle window.
  // adder_c0 doubles as the carry flip-flop for nibbles after the first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      a_word     <= '0;
      b_word     <= '0;
      is_load    <= 1'b0;
      nib_idx    <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
      negative   <= 1'b0;
      zero       <= 1'b0;
      adder_a    <= 4'h0;
      adder_b    <= 4'h0;
      adder_c0   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_word     <= a_sel;
            b_word     <= b_sel;
            is_load    <= (op == OP_LOAD);
            result     <= '0;
            nib_idx    <= '0;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            adder_a    <= a_sel[3:0];
            adder_b    <= b_sel[3:0];
            adder_c0   <= cin_sel;
            state      <= ST_PRESENT;
          end
        end

        ST_PRESENT: begin
          settle_cnt <= settle_cnt - CW'(1);
          if (settle_cnt == CW'(1)) begin
            state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          result <= merged;
          if (nib_idx == LAST_IDX) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            carry_out <= adder_c4;
            overflow  <= ~is_load
                         & (a_word[WORD_WIDTH-1] == b_word[WORD_WIDTH-1])
                         & (merged[WORD_WIDTH-1] != a_word[WORD_WIDTH-1]);
            negative  <= merged[WORD_WIDTH-1];
            zero      <= (merged == '0);
            adder_a   <= 4'h0;
            adder_b   <= 4'h0;
            adder_c0  <= 1'b0;
            state     <= ST_DONE;
          end else begin
            nib_idx    <= nib_next;
            settle_cnt <= SETTLE_LOAD;
            adder_a    <= a_word[{nib_next, 2'b00} +: 4];
            adder_b    <= b_word[{nib_next, 2'b00} +: 4];
            adder_c0   <= adder_c4;
            state      <= ST_PRESENT;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
